bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_bus_rr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter funnelling NrHosts request ports onto one device port.
// An in-order ID FIFO routes each downstream response back to the host that issued it.
module bus_rr_arbiter #(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NrHosts-1:0]                     host_req_i,
    output logic [NrHosts-1:0]                     host_gnt_o,
    input  logic [AddressWidth-1:0]                host_addr_i  [NrHosts],
    input  logic [NrHosts-1:0]                     host_we_i,
    input  logic [DataWidth/8-1:0]                 host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]                   host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]                     host_rvalid_o,
    output logic [DataWidth-1:0]                   host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]                     host_err_o,
    output logic                                   dev_req_o,
    input  logic                                   dev_gnt_i,
    output logic [AddressWidth-1:0]                dev_addr_o,
    output logic                                   dev_we_o,
    output logic [DataWidth/8-1:0]                 dev_be_o,
    output logic [DataWidth-1:0]                   dev_wdata_o,
    input  logic                                   dev_rvalid_i,
    input  logic [DataWidth-1:0]                   dev_rdata_i,
    input  logic                                   dev_err_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
    output logic                                   spurious_rsp_o
);

    localparam int unsigned IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]  fifo_q [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            spurious_q, spurious_d;

    logic [IdW-1:0]  sel_c, cand_c, head_c;
    logic            any_req_c, full_c, empty_c, accept_c, pop_c;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        sel_c     = '0;
        cand_c    = '0;
        any_req_c = 1'b0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            cand_c = IdW'((32'(rr_ptr_q) + i) % NrHosts);
            if (!any_req_c && host_req_i[cand_c]) begin
                sel_c     = cand_c;
                any_req_c = 1'b1;
            end
        end
    end

    assign full_c    = (cnt_q == CntW'(MaxOutstanding));
    assign empty_c   = (cnt_q == '0);
    assign dev_req_o = any_req_c && !full_c;
    // Grants are suppressed while reset is held even though dev_req_o is live.
    assign accept_c  = dev_req_o && dev_gnt_i && rst_ni;
    assign pop_c     = dev_rvalid_i && !empty_c;
    assign head_c    = fifo_q[rd_ptr_q];

    assign host_gnt_o  = accept_c ? (NrHosts'(1) << sel_c) : '0;
    assign dev_addr_o  = any_req_c ? host_addr_i[sel_c]  : '0;
    assign dev_we_o    = any_req_c ? host_we_i[sel_c]    : 1'b0;
    assign dev_be_o    = any_req_c ? host_be_i[sel_c]    : '0;
    assign dev_wdata_o = any_req_c ? host_wdata_i[sel_c] : '0;

    // Response demux to the host at the head of the ID FIFO.
    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = pop_c && (head_c == IdW'(h));
            host_err_o[h]    = host_rvalid_o[h] && dev_err_i;
            host_rdata_o[h]  = host_rvalid_o[h] ? dev_rdata_i : '0;
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        spurious_d = spurious_q;
        if (accept_c) begin
            rr_ptr_d = (sel_c == IdW'(NrHosts - 1)) ? '0 : sel_c + IdW'(1);
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({accept_c, pop_c})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (dev_rvalid_i && empty_c) begin
            spurious_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            spurious_q <= spurious_d;
        end
    end

    // ID storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk_i) begin
        if (accept_c) begin
            fifo_q[wr_ptr_q] <= sel_c;
        end
    end

    assign outstanding_o  = cnt_q;
    assign spurious_rsp_o = spurious_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Randomised and directed bench for bus_rr_arbiter against a queue-based host-ID model.
module tb_bus_rr_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;
    localparam int BW = DW / 8;
    localparam int CW = $clog2(MO + 1);

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  host_req, host_gnt, host_we, host_rvalid, host_err;
    logic [AW-1:0] host_addr  [N];
    logic [BW-1:0] host_be    [N];
    logic [DW-1:0] host_wdata [N];
    logic [DW-1:0] host_rdata [N];
    logic          dev_req, dev_gnt, dev_we, dev_rvalid, dev_err;
    logic [AW-1:0] dev_addr;
    logic [BW-1:0] dev_be;
    logic [DW-1:0] dev_wdata, dev_rdata;
    logic [CW-1:0] outstanding;
    logic          spurious;

    bus_rr_arbiter #(
        .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_gnt_o(host_gnt),
        .host_addr_i(host_addr), .host_we_i(host_we), .host_be_i(host_be),
        .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .dev_req_o(dev_req), .dev_gnt_i(dev_gnt),
        .dev_addr_o(dev_addr), .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
        .outstanding_o(outstanding), .spurious_rsp_o(spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: list of outstanding host IDs in issue order, plus pointer and sticky flag.
    int q[$];
    int rr;
    bit spur;
    int m_sel;
    bit m_acc, m_pop;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        rr   = 0;
        spur = 0;
    endtask

    // Sample at the falling edge, compare everything against the model.
    task automatic eval_cycle();
        logic [N-1:0]  e_gnt, e_rv, e_err;
        logic [127:0]  e_fields;
        logic [DW-1:0] e_rd;
        bit            any, e_req;
        @(negedge clk);
        m_sel = -1;
        for (int k = 0; k < N; k++) begin
            int h;
            h = (rr + k) % N;
            if (m_sel < 0 && host_req[h]) m_sel = h;
        end
        any   = (m_sel >= 0);
        e_req = any && (q.size() != MO);
        m_acc = e_req && dev_gnt && rst_n;
        m_pop = dev_rvalid && (q.size() > 0);
        e_gnt = m_acc ? (N'(1) << m_sel) : '0;
        e_fields = '0;
        if (any) e_fields = {host_addr[m_sel], host_we[m_sel], host_be[m_sel], host_wdata[m_sel]};
        e_rv  = m_pop ? (N'(1) << q[0]) : '0;
        e_err = (m_pop && dev_err) ? (N'(1) << q[0]) : '0;
        chk("gnt", host_gnt, e_gnt);
        chk("dev_req", dev_req, e_req);
        chk("dev_fields", {dev_addr, dev_we, dev_be, dev_wdata}, e_fields);
        chk("rvalid", host_rvalid, e_rv);
        chk("err", host_err, e_err);
        for (int h = 0; h < N; h++) begin
            e_rd = (m_pop && q[0] == h) ? dev_rdata : '0;
            chk($sformatf("rdata%0d", h), host_rdata[h], e_rd);
        end
        chk("outstanding", outstanding, q.size());
        chk("spurious", spurious, spur);
    endtask

    task automatic adv_cycle();
        if (rst_n) begin
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                q.push_back(m_sel);
                rr = (m_sel + 1) % N;
            end
            if (dev_rvalid && !m_pop) spur = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        host_req   = '0;
        host_we    = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        dev_err    = 1'b0;
        for (int h = 0; h < N; h++) begin
            host_addr[h]  = AW'(32'h1000_0000 + h * 32'h10);
            host_be[h]    = BW'(h + 1);
            host_wdata[h] = DW'(32'hA000_0000 + h);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        eval_cycle();
        adv_cycle();
        rst_n = 1'b1;
    endtask

    task automatic randomize_inputs();
        host_req   = N'($urandom_range(0, (1 << N) - 1));
        host_we    = N'($urandom);
        dev_gnt    = ($urandom % 4) != 0;
        dev_rvalid = ($urandom % 3) == 0;
        dev_rdata  = DW'($urandom);
        dev_err    = ($urandom % 5) == 0;
        for (int h = 0; h < N; h++) begin
            host_addr[h]  = AW'($urandom);
            host_be[h]    = BW'($urandom);
            host_wdata[h] = DW'($urandom);
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        eval_cycle();
        chk("rst_outstanding", outstanding, 0);
        chk("rst_spurious", spurious, 0);
        adv_cycle();
        rst_n = 1'b1;

        // Alternating grants with one-cycle responses, including push+pop at count 1.
        clear_inputs();
        do_reset();
        host_req = 3'b011;
        dev_gnt  = 1'b1;
        eval_cycle();
        chk("alt_gnt0", host_gnt, 3'b001);
        adv_cycle();
        dev_rvalid = 1'b1;
        dev_rdata  = 32'hDEADBEEF;
        eval_cycle();
        chk("alt_gnt1", host_gnt, 3'b010);
        chk("pp_rvalid", host_rvalid, 3'b001);
        chk("pp_rdata0", host_rdata[0], 32'hDEADBEEF);
        chk("pp_rdata1", host_rdata[1], 32'h0);
        adv_cycle();
        dev_rdata = 32'h2222_2222;
        eval_cycle();
        chk("pp_outstanding", outstanding, 1);
        chk("alt_gnt2", host_gnt, 3'b001);
        chk("alt_rvalid1", host_rvalid, 3'b010);
        adv_cycle();
        host_req  = '0;
        dev_rdata = 32'h3333_3333;
        eval_cycle();
        chk("alt_rvalid0", host_rvalid, 3'b001);
        adv_cycle();
        dev_rvalid = 1'b0;
        eval_cycle();
        chk("alt_drained", outstanding, 0);
        adv_cycle();

        // Full FIFO blocks requests; a pop does not bypass the full condition.
        clear_inputs();
        do_reset();
        host_req = 3'b001;
        dev_gnt  = 1'b1;
        eval_cycle(); adv_cycle();
        eval_cycle(); adv_cycle();
        eval_cycle();
        chk("full_outstanding", outstanding, 2);
        chk("full_req", dev_req, 1'b0);
        chk("full_gnt", host_gnt, 3'b000);
        adv_cycle();
        dev_rvalid = 1'b1;
        eval_cycle();
        chk("nobypass_req", dev_req, 1'b0);
        chk("nobypass_rvalid", host_rvalid, 3'b001);
        adv_cycle();
        dev_rvalid = 1'b0;
        eval_cycle();
        chk("refill_outstanding", outstanding, 1);
        chk("refill_gnt", host_gnt, 3'b001);
        adv_cycle();

        // Spurious response, then an error response to host 1.
        clear_inputs();
        do_reset();
        dev_rvalid = 1'b1;
        eval_cycle();
        chk("spur_rvalid", host_rvalid, 3'b000);
        chk("spur_before", spurious, 1'b0);
        adv_cycle();
        dev_rvalid = 1'b0;
        host_req   = 3'b010;
        dev_gnt    = 1'b1;
        eval_cycle();
        chk("spur_set", spurious, 1'b1);
        chk("err_gnt", host_gnt, 3'b010);
        adv_cycle();
        host_req   = '0;
        dev_rvalid = 1'b1;
        dev_err    = 1'b1;
        eval_cycle();
        chk("err_vec", host_err, 3'b010);
        chk("err_rvalid", host_rvalid, 3'b010);
        adv_cycle();
        dev_rvalid = 1'b0;
        dev_err    = 1'b0;
        eval_cycle();
        chk("spur_held", spurious, 1'b1);
        adv_cycle();

        // Mid-transaction reset clears count and pointer.
        clear_inputs();
        do_reset();
        host_req = 3'b010;
        dev_gnt  = 1'b1;
        eval_cycle(); adv_cycle();
        eval_cycle(); adv_cycle();
        eval_cycle();
        chk("prerst_outstanding", outstanding, 2);
        adv_cycle();
        host_req = 3'b110;
        rst_n    = 1'b0;
        model_reset();
        eval_cycle();
        chk("inrst_outstanding", outstanding, 0);
        chk("inrst_gnt", host_gnt, 3'b000);
        chk("inrst_req", dev_req, 1'b1);
        adv_cycle();
        rst_n = 1'b1;
        eval_cycle();
        chk("postrst_gnt", host_gnt, 3'b010);
        adv_cycle();

        // Random traffic with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            randomize_inputs();
            if (($urandom % 400) == 0) begin
                do_reset();
            end else begin
                eval_cycle();
                adv_cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
